// File: rtl/dodec_arbiter.sv
// 12-requester grant-and-hold arbiter using IBM bit ordering (i_req[11] = requester 1).
// Fixed (highest number wins) or rotating priority, with an optional hold timeout.
module dodec_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int MAX_HOLD    = 0,
    parameter int HOLD_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [11:0] i_req,
    input  logic [11:0] i_mask,
    input  logic        i_done,
    output logic [11:0] o_gnt,
    output logic [3:0]  o_gnt_num,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state_q;
    logic [11:0]         gnt_q;
    logic [3:0]          num_q;
    logic                timeout_q;
    logic [3:0]          ptr_q;
    logic [3:0]          ptr_d;
    logic [HOLD_W-1:0]   hold_q;

    logic [11:0]         elig;
    logic [3:0]          start;
    logic [4:0]          cand;
    logic [3:0]          idx;
    logic                win_found;
    logic [3:0]          win_num;
    logic [11:0]         win_gnt;
    logic                owner_req;
    logic                hold_expired;
    logic                rel;

    assign elig  = i_req & ~i_mask;
    assign start = (ROUND_ROBIN != 0) ? ptr_q : 4'd12;

    // Walk numbers start, start-1, ..., 1, 12, ... ; number n lives at bit 12-n.
    always_comb begin
        win_found = 1'b0;
        win_num   = 4'd0;
        win_gnt   = 12'h000;
        cand      = 5'd0;
        idx       = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cand = {1'b0, start} + 5'd12 - 5'(i);
            if (cand > 5'd12) begin
                cand = cand - 5'd12;
            end
            idx = 4'(5'd12 - cand);
            if (!win_found && elig[idx]) begin
                win_found    = 1'b1;
                win_num      = cand[3:0];
                win_gnt[idx] = 1'b1;
            end
        end
    end

    assign ptr_d        = (win_num == 4'd1) ? 4'd12 : win_num - 4'd1;
    assign owner_req    = |(i_req & gnt_q);
    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
    assign rel          = i_done || !owner_req || hold_expired;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            gnt_q     <= 12'h000;
            num_q     <= 4'd0;
            timeout_q <= 1'b0;
            ptr_q     <= 4'd12;
            hold_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q <= OWNED;
                        gnt_q   <= win_gnt;
                        num_q   <= win_num;
                        hold_q  <= HOLD_W'(1);
                        if (ROUND_ROBIN != 0) begin
                            ptr_q <= ptr_d;
                        end
                    end
                end
                OWNED: begin
                    // Timeout is flagged only when it is the sole cause of release.
                    if (rel) begin
                        state_q   <= IDLE;
                        gnt_q     <= 12'h000;
                        num_q     <= 4'd0;
                        hold_q    <= '0;
                        timeout_q <= hold_expired && !i_done && owner_req;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_num = num_q;
    assign o_busy    = (state_q == OWNED);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_dodec_arbiter.sv
// Bench for dodec_arbiter: round-robin, fixed-priority and timeout instances share stimulus;
// expectations are queued when stimulus is driven and checked after the sampling edge.
module tb_dodec_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] req;
    logic [11:0] mask;
    logic        done;

    logic [11:0] gnt_rr, gnt_fx, gnt_to;
    logic [3:0]  num_rr, num_fx, num_to;
    logic        busy_rr, busy_fx, busy_to;
    logic        to_rr, to_fx, to_to;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dodec_arbiter #(.ROUND_ROBIN(1), .MAX_HOLD(0), .HOLD_W(8)) u_rr (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_mask(mask), .i_done(done),
        .o_gnt(gnt_rr), .o_gnt_num(num_rr), .o_busy(busy_rr), .o_timeout(to_rr));

    dodec_arbiter #(.ROUND_ROBIN(0), .MAX_HOLD(0), .HOLD_W(8)) u_fx (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_mask(mask), .i_done(done),
        .o_gnt(gnt_fx), .o_gnt_num(num_fx), .o_busy(busy_fx), .o_timeout(to_fx));

    dodec_arbiter #(.ROUND_ROBIN(1), .MAX_HOLD(4), .HOLD_W(8)) u_to (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_mask(mask), .i_done(done),
        .o_gnt(gnt_to), .o_gnt_num(num_to), .o_busy(busy_to), .o_timeout(to_to));

    typedef struct {
        logic        rst;
        logic [11:0] req;
        logic [11:0] mask;
        logic        done;
        logic [11:0] gnt;
        logic [3:0]  num;
        logic        busy;
        logic        to;
    } vec_t;

    typedef struct {
        int          sel;   // 0 = round-robin, 1 = fixed, 2 = timeout instance
        int          tag;
        logic [11:0] gnt;
        logic [3:0]  num;
        logic        busy;
        logic        to;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[25];

    function automatic logic [11:0] onehot(input int k);
        logic [11:0] one;
        one = 12'h001;
        return one << (12 - k);
    endfunction

    task automatic drive(input logic r, input logic [11:0] rq, input logic [11:0] mk, input logic d);
        rst  = r;
        req  = rq;
        mask = mk;
        done = d;
    endtask

    task automatic expect_out(input int sel, input int tag, input logic [11:0] g,
                              input logic [3:0] n, input logic b, input logic t);
        exp_t e;
        e.sel = sel; e.tag = tag; e.gnt = g; e.num = n; e.busy = b; e.to = t;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [11:0] ag;
        logic [3:0]  an;
        logic        ab, at;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       begin ag = gnt_rr; an = num_rr; ab = busy_rr; at = to_rr; end
                1:       begin ag = gnt_fx; an = num_fx; ab = busy_fx; at = to_fx; end
                default: begin ag = gnt_to; an = num_to; ab = busy_to; at = to_to; end
            endcase
            checks++;
            if ({ag, an, ab, at} !== {e.gnt, e.num, e.busy, e.to}) begin
                errors++;
                $display("FAIL dut%0d tag%0d: got gnt=%h num=%0d busy=%b to=%b, want gnt=%h num=%0d busy=%b to=%b",
                         e.sel, e.tag, ag, an, ab, at, e.gnt, e.num, e.busy, e.to);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, req, mask, done | gnt, num, busy, timeout  (round-robin instance)
        tbl[0]  = '{1'b1, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 12'h801, 12'h000, 1'b0, 12'h001, 4'd12, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 12'h801, 12'h000, 1'b1, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 12'h801, 12'h000, 1'b0, 12'h800, 4'd1,  1'b1, 1'b0};
        tbl[4]  = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[5]  = '{1'b0, 12'h400, 12'h000, 1'b0, 12'h400, 4'd2,  1'b1, 1'b0};
        tbl[6]  = '{1'b1, 12'h400, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 12'h802, 12'h000, 1'b0, 12'h002, 4'd11, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 12'h802, 12'h000, 1'b1, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 12'h802, 12'h000, 1'b0, 12'h800, 4'd1,  1'b1, 1'b0};
        tbl[10] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[11] = '{1'b0, 12'h208, 12'h200, 1'b0, 12'h008, 4'd9,  1'b1, 1'b0};
        tbl[12] = '{1'b0, 12'h208, 12'h000, 1'b0, 12'h008, 4'd9,  1'b1, 1'b0};
        tbl[13] = '{1'b0, 12'h208, 12'h000, 1'b0, 12'h008, 4'd9,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 12'h208, 12'h000, 1'b1, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[15] = '{1'b0, 12'h208, 12'h000, 1'b0, 12'h200, 4'd3,  1'b1, 1'b0};
        tbl[16] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[17] = '{1'b0, 12'h020, 12'h000, 1'b0, 12'h020, 4'd7,  1'b1, 1'b0};
        tbl[18] = '{1'b0, 12'h220, 12'h000, 1'b0, 12'h020, 4'd7,  1'b1, 1'b0};
        tbl[19] = '{1'b0, 12'h220, 12'h000, 1'b1, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[20] = '{1'b0, 12'h220, 12'h000, 1'b0, 12'h200, 4'd3,  1'b1, 1'b0};
        tbl[21] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[22] = '{1'b0, 12'h000, 12'h000, 1'b1, 12'h000, 4'd0,  1'b0, 1'b0};
        tbl[23] = '{1'b0, 12'h020, 12'h000, 1'b1, 12'h020, 4'd7,  1'b1, 1'b0};
        tbl[24] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 4'd0,  1'b0, 1'b0};

        drive(1'b1, 12'h000, 12'h000, 1'b0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].mask, tbl[i].done);
            expect_out(0, 100 + i, tbl[i].gnt, tbl[i].num, tbl[i].busy, tbl[i].to);
            tick();
        end

        // All twelve requesting: rotation 12..1,12 with a dead cycle; fixed stays on 12.
        drive(1'b1, 12'h000, 12'h000, 1'b0);
        expect_out(0, 200, 12'h000, 4'd0, 1'b0, 1'b0);
        expect_out(1, 200, 12'h000, 4'd0, 1'b0, 1'b0);
        tick();
        for (int k = 12; k >= 1; k--) begin
            drive(1'b0, 12'hFFF, 12'h000, 1'b0);
            expect_out(0, 200 + k, onehot(k), 4'(k), 1'b1, 1'b0);
            expect_out(1, 200 + k, 12'h001, 4'd12, 1'b1, 1'b0);
            tick();
            drive(1'b0, 12'hFFF, 12'h000, 1'b1);
            expect_out(0, 220 + k, 12'h000, 4'd0, 1'b0, 1'b0);
            expect_out(1, 220 + k, 12'h000, 4'd0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 12'hFFF, 12'h000, 1'b0);
        expect_out(0, 240, 12'h001, 4'd12, 1'b1, 1'b0);
        tick();

        // Timeout after four held cycles, then re-grant.
        drive(1'b1, 12'h000, 12'h000, 1'b0);
        expect_out(2, 300, 12'h000, 4'd0, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 12'h080, 12'h000, 1'b0);
            expect_out(2, 300 + c, 12'h080, 4'd5, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 12'h080, 12'h000, 1'b0);
        expect_out(2, 305, 12'h000, 4'd0, 1'b0, 1'b1);
        expect_out(0, 305, 12'h080, 4'd5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 12'h080, 12'h000, 1'b0);
        expect_out(2, 306, 12'h080, 4'd5, 1'b1, 1'b0);
        tick();

        // i_done coinciding with hold expiry: plain release, no timeout pulse.
        for (int c = 2; c <= 4; c++) begin
            drive(1'b0, 12'h080, 12'h000, 1'b0);
            expect_out(2, 310 + c, 12'h080, 4'd5, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 12'h080, 12'h000, 1'b1);
        expect_out(2, 320, 12'h000, 4'd0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 12'h080, 12'h000, 1'b0);
        expect_out(2, 321, 12'h080, 4'd5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 12'h000, 12'h000, 1'b0);
        expect_out(2, 322, 12'h000, 4'd0, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
